// File: rtl/reg_writeback_queue.sv
// Writeback queue feeding the two register-file write ports.
// Channel A (ALU results) drains to port A, channel B (load/store results)
// drains to port B. Each channel owns a small FIFO. When both heads target
// the same register in the same cycle, ALU goes first and the load lands one
// cycle later, so the load value is always the last one written.
//
// Handshake: a producer presents xValid_i with its addr/data. The beat is
// taken on a rising edge where xValid_i && xReady_o. xReady_o depends only on
// the registered occupancy (count < DEPTH), never on a same-cycle pop. A
// producer seeing xReady_o=0 must hold its beat until it is accepted.
module reg_writeback_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 16
) (
    input  logic                         clock_i,
    input  logic                         reset_i,
    input  logic                         aluValid_i,
    output logic                         aluReady_o,
    input  logic [ADDR_W-1:0]            aluAddr_i,
    input  logic [DATA_W-1:0]            aluData_i,
    input  logic                         lsValid_i,
    output logic                         lsReady_o,
    input  logic [ADDR_W-1:0]            lsAddr_i,
    input  logic [DATA_W-1:0]            lsData_i,
    input  logic                         stall_i,
    output logic                         portAWriteEnable_o,
    output logic [ADDR_W-1:0]            portAWriteAddress_o,
    output logic [DATA_W-1:0]            portAWriteData_o,
    output logic                         portBWriteEnable_o,
    output logic [ADDR_W-1:0]            portBWriteAddress_o,
    output logic [DATA_W-1:0]            portBWriteData_o,
    output logic [$clog2(DEPTH+1)-1:0]   aluCount_o,
    output logic [$clog2(DEPTH+1)-1:0]   lsCount_o,
    output logic                         idle_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
    localparam logic [PTR_W-1:0] ONE_PTR  = PTR_W'(1);

    // FIFO storage
    logic [ADDR_W-1:0] alu_addr_mem [DEPTH];
    logic [DATA_W-1:0] alu_data_mem [DEPTH];
    logic [ADDR_W-1:0] ls_addr_mem  [DEPTH];
    logic [DATA_W-1:0] ls_data_mem  [DEPTH];

    logic [PTR_W-1:0] alu_wr_ptr, alu_rd_ptr;
    logic [PTR_W-1:0] ls_wr_ptr, ls_rd_ptr;
    logic [CNT_W-1:0] alu_count, ls_count;

    logic alu_push, ls_push;
    logic alu_pop, ls_pop;
    logic ls_eligible, collision;

    logic [ADDR_W-1:0] alu_head_addr, ls_head_addr;
    logic [DATA_W-1:0] alu_head_data, ls_head_data;

    // Handshake, drain and collision decisions for this cycle
    always_comb begin
        aluReady_o    = (alu_count < FULL_CNT);
        lsReady_o     = (ls_count < FULL_CNT);
        alu_push      = aluValid_i && aluReady_o;
        ls_push       = lsValid_i && lsReady_o;
        alu_head_addr = alu_addr_mem[alu_rd_ptr];
        alu_head_data = alu_data_mem[alu_rd_ptr];
        ls_head_addr  = ls_addr_mem[ls_rd_ptr];
        ls_head_data  = ls_data_mem[ls_rd_ptr];
        alu_pop       = !stall_i && (alu_count != '0);
        ls_eligible   = !stall_i && (ls_count != '0);
        // Same destination on both heads: the load waits one cycle so it lands last.
        collision     = alu_pop && ls_eligible && (alu_head_addr == ls_head_addr);
        ls_pop        = ls_eligible && !collision;
    end

    // Entry storage; stale contents are harmless once pointers are cleared.
    always_ff @(posedge clock_i) begin
        if (alu_push) begin
            alu_addr_mem[alu_wr_ptr] <= aluAddr_i;
            alu_data_mem[alu_wr_ptr] <= aluData_i;
        end
        if (ls_push) begin
            ls_addr_mem[ls_wr_ptr] <= lsAddr_i;
            ls_data_mem[ls_wr_ptr] <= lsData_i;
        end
    end

    // Channel A pointers and occupancy
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            alu_wr_ptr <= '0;
            alu_rd_ptr <= '0;
            alu_count  <= '0;
        end else begin
            if (alu_push) alu_wr_ptr <= alu_wr_ptr + ONE_PTR;
            if (alu_pop)  alu_rd_ptr <= alu_rd_ptr + ONE_PTR;
            case ({alu_push, alu_pop})
                2'b10:   alu_count <= alu_count + ONE_CNT;
                2'b01:   alu_count <= alu_count - ONE_CNT;
                default: alu_count <= alu_count;
            endcase
        end
    end

    // Channel B pointers and occupancy
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            ls_wr_ptr <= '0;
            ls_rd_ptr <= '0;
            ls_count  <= '0;
        end else begin
            if (ls_push) ls_wr_ptr <= ls_wr_ptr + ONE_PTR;
            if (ls_pop)  ls_rd_ptr <= ls_rd_ptr + ONE_PTR;
            case ({ls_push, ls_pop})
                2'b10:   ls_count <= ls_count + ONE_CNT;
                2'b01:   ls_count <= ls_count - ONE_CNT;
                default: ls_count <= ls_count;
            endcase
        end
    end

    // Registered write ports; addr/data hold when no entry is popped.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            portAWriteEnable_o  <= 1'b0;
            portAWriteAddress_o <= '0;
            portAWriteData_o    <= '0;
            portBWriteEnable_o  <= 1'b0;
            portBWriteAddress_o <= '0;
            portBWriteData_o    <= '0;
        end else begin
            portAWriteEnable_o <= alu_pop;
            portBWriteEnable_o <= ls_pop;
            if (alu_pop) begin
                portAWriteAddress_o <= alu_head_addr;
                portAWriteData_o    <= alu_head_data;
            end
            if (ls_pop) begin
                portBWriteAddress_o <= ls_head_addr;
                portBWriteData_o    <= ls_head_data;
            end
        end
    end

    // Occupancy and idle status
    always_comb begin
        aluCount_o = alu_count;
        lsCount_o  = ls_count;
        idle_o     = (alu_count == '0) && (ls_count == '0) &&
                     !portAWriteEnable_o && !portBWriteEnable_o;
    end

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Directed bench for reg_writeback_queue: each scenario task drives its own
// vectors and checks outputs 1 ns after the rising edge.
module tb_reg_writeback_queue;

    logic        clock_i = 1'b0;
    logic        reset_i = 1'b0;
    logic        aluValid_i = 1'b0;
    logic        aluReady_o;
    logic [4:0]  aluAddr_i = '0;
    logic [15:0] aluData_i = '0;
    logic        lsValid_i = 1'b0;
    logic        lsReady_o;
    logic [4:0]  lsAddr_i = '0;
    logic [15:0] lsData_i = '0;
    logic        stall_i = 1'b0;
    logic        portAWriteEnable_o;
    logic [4:0]  portAWriteAddress_o;
    logic [15:0] portAWriteData_o;
    logic        portBWriteEnable_o;
    logic [4:0]  portBWriteAddress_o;
    logic [15:0] portBWriteData_o;
    logic [2:0]  aluCount_o;
    logic [2:0]  lsCount_o;
    logic        idle_o;

    int checks = 0;
    int errors = 0;

    reg_writeback_queue #(.DEPTH(4), .ADDR_W(5), .DATA_W(16)) dut (
        .clock_i(clock_i), .reset_i(reset_i),
        .aluValid_i(aluValid_i), .aluReady_o(aluReady_o),
        .aluAddr_i(aluAddr_i), .aluData_i(aluData_i),
        .lsValid_i(lsValid_i), .lsReady_o(lsReady_o),
        .lsAddr_i(lsAddr_i), .lsData_i(lsData_i),
        .stall_i(stall_i),
        .portAWriteEnable_o(portAWriteEnable_o),
        .portAWriteAddress_o(portAWriteAddress_o),
        .portAWriteData_o(portAWriteData_o),
        .portBWriteEnable_o(portBWriteEnable_o),
        .portBWriteAddress_o(portBWriteAddress_o),
        .portBWriteData_o(portBWriteData_o),
        .aluCount_o(aluCount_o), .lsCount_o(lsCount_o),
        .idle_o(idle_o)
    );

    // Clock and sampling point
    always #5 clock_i = ~clock_i;

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    task automatic test_reset();
        reset_i = 1'b1; aluValid_i = 1'b1; aluAddr_i = 5'd9; aluData_i = 16'h1234;
        tick(); tick();
        checks++; if (aluCount_o !== 3'd0) begin errors++; $display("FAIL reset_alu_count got %0d exp 0", aluCount_o); end
        checks++; if (lsCount_o !== 3'd0) begin errors++; $display("FAIL reset_ls_count got %0d exp 0", lsCount_o); end
        checks++; if ({portAWriteEnable_o, portBWriteEnable_o} !== 2'b00) begin errors++; $display("FAIL reset_we got %b exp 00", {portAWriteEnable_o, portBWriteEnable_o}); end
        checks++; if (idle_o !== 1'b1) begin errors++; $display("FAIL reset_idle got %b exp 1", idle_o); end
        checks++; if ({aluReady_o, lsReady_o} !== 2'b11) begin errors++; $display("FAIL reset_ready got %b exp 11", {aluReady_o, lsReady_o}); end
        checks++; if ({portAWriteAddress_o, portAWriteData_o} !== 21'd0) begin errors++; $display("FAIL reset_porta got %h exp 0", {portAWriteAddress_o, portAWriteData_o}); end
        reset_i = 1'b0; aluValid_i = 1'b0;
        tick();
        checks++; if (portAWriteEnable_o !== 1'b0) begin errors++; $display("FAIL reset_no_write got %b exp 0", portAWriteEnable_o); end
    endtask

    task automatic test_single_alu();
        aluValid_i = 1'b1; aluAddr_i = 5'd3; aluData_i = 16'hBEEF;
        tick();  // edge N
        aluValid_i = 1'b0;
        checks++; if (portAWriteEnable_o !== 1'b0) begin errors++; $display("FAIL single_early_we got %b exp 0", portAWriteEnable_o); end
        checks++; if (aluCount_o !== 3'd1) begin errors++; $display("FAIL single_count got %0d exp 1", aluCount_o); end
        tick();  // edge N+1
        checks++; if (portAWriteEnable_o !== 1'b1) begin errors++; $display("FAIL single_we got %b exp 1", portAWriteEnable_o); end
        checks++; if (portAWriteAddress_o !== 5'd3) begin errors++; $display("FAIL single_addr got %0d exp 3", portAWriteAddress_o); end
        checks++; if (portAWriteData_o !== 16'hBEEF) begin errors++; $display("FAIL single_data got %h exp beef", portAWriteData_o); end
        checks++; if (portBWriteEnable_o !== 1'b0) begin errors++; $display("FAIL single_b_we got %b exp 0", portBWriteEnable_o); end
        tick();
        checks++; if (portAWriteEnable_o !== 1'b0) begin errors++; $display("FAIL single_one_cycle got %b exp 0", portAWriteEnable_o); end
        checks++; if ({portAWriteAddress_o, portAWriteData_o} !== {5'd3, 16'hBEEF}) begin errors++; $display("FAIL single_hold got %h exp 3/beef", {portAWriteAddress_o, portAWriteData_o}); end
        checks++; if (idle_o !== 1'b1) begin errors++; $display("FAIL single_idle got %b exp 1", idle_o); end
    endtask

    task automatic test_full_backpressure();
        stall_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            aluValid_i = 1'b1; aluAddr_i = 5'(10 + i); aluData_i = 16'hA000 + 16'(i);
            if (i == 4) begin
                checks++; if (aluReady_o !== 1'b0) begin errors++; $display("FAIL full_ready_before got %b exp 0", aluReady_o); end
            end
            tick();
        end
        aluValid_i = 1'b0;
        checks++; if (aluCount_o !== 3'd4) begin errors++; $display("FAIL full_count got %0d exp 4", aluCount_o); end
        checks++; if (aluReady_o !== 1'b0) begin errors++; $display("FAIL full_ready got %b exp 0", aluReady_o); end
        checks++; if (portAWriteEnable_o !== 1'b0) begin errors++; $display("FAIL full_stall_we got %b exp 0", portAWriteEnable_o); end
        checks++; if (idle_o !== 1'b0) begin errors++; $display("FAIL full_idle got %b exp 0", idle_o); end
        stall_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({portAWriteEnable_o, portAWriteAddress_o, portAWriteData_o} !== {1'b1, 5'(10 + i), 16'hA000 + 16'(i)}) begin
                errors++;
                $display("FAIL full_drain%0d got we=%b %0d/%h exp 1 %0d/%h", i, portAWriteEnable_o,
                         portAWriteAddress_o, portAWriteData_o, 10 + i, 16'hA000 + 16'(i));
            end
        end
        tick();
        checks++; if (portAWriteEnable_o !== 1'b0) begin errors++; $display("FAIL full_no_fifth got %b exp 0", portAWriteEnable_o); end
        checks++; if (aluCount_o !== 3'd0) begin errors++; $display("FAIL full_empty got %0d exp 0", aluCount_o); end
    endtask

    task automatic test_collision();
        aluValid_i = 1'b1; aluAddr_i = 5'd7; aluData_i = 16'h0001;
        lsValid_i  = 1'b1; lsAddr_i  = 5'd7; lsData_i  = 16'h0002;
        tick();
        aluValid_i = 1'b0; lsValid_i = 1'b0;
        tick();  // cycle k
        checks++; if ({portAWriteEnable_o, portAWriteAddress_o, portAWriteData_o} !== {1'b1, 5'd7, 16'h0001}) begin errors++; $display("FAIL coll_a got %b %0d/%h exp 1 7/0001", portAWriteEnable_o, portAWriteAddress_o, portAWriteData_o); end
        checks++; if (portBWriteEnable_o !== 1'b0) begin errors++; $display("FAIL coll_b_hold got %b exp 0", portBWriteEnable_o); end
        checks++; if (lsCount_o !== 3'd1) begin errors++; $display("FAIL coll_ls_count got %0d exp 1", lsCount_o); end
        tick();  // cycle k+1
        checks++; if ({portBWriteEnable_o, portBWriteAddress_o, portBWriteData_o} !== {1'b1, 5'd7, 16'h0002}) begin errors++; $display("FAIL coll_b got %b %0d/%h exp 1 7/0002", portBWriteEnable_o, portBWriteAddress_o, portBWriteData_o); end
        checks++; if (portAWriteEnable_o !== 1'b0) begin errors++; $display("FAIL coll_a_after got %b exp 0", portAWriteEnable_o); end
        tick();
        checks++; if (idle_o !== 1'b1) begin errors++; $display("FAIL coll_idle got %b exp 1", idle_o); end
    endtask

    task automatic test_parallel();
        aluValid_i = 1'b1; aluAddr_i = 5'd1; aluData_i = 16'h1111;
        lsValid_i  = 1'b1; lsAddr_i  = 5'd2; lsData_i  = 16'h2222;
        tick();
        aluValid_i = 1'b0; lsValid_i = 1'b0;
        tick();
        checks++; if ({portAWriteEnable_o, portAWriteAddress_o, portAWriteData_o} !== {1'b1, 5'd1, 16'h1111}) begin errors++; $display("FAIL par_a got %b %0d/%h exp 1 1/1111", portAWriteEnable_o, portAWriteAddress_o, portAWriteData_o); end
        checks++; if ({portBWriteEnable_o, portBWriteAddress_o, portBWriteData_o} !== {1'b1, 5'd2, 16'h2222}) begin errors++; $display("FAIL par_b got %b %0d/%h exp 1 2/2222", portBWriteEnable_o, portBWriteAddress_o, portBWriteData_o); end
        tick();
        checks++; if ({portAWriteEnable_o, portBWriteEnable_o} !== 2'b00) begin errors++; $display("FAIL par_done got %b exp 00", {portAWriteEnable_o, portBWriteEnable_o}); end
    endtask

    task automatic test_back_to_back();
        // Six LS beats on consecutive edges: one write per cycle, in order, across a pointer wrap.
        for (int i = 0; i < 7; i++) begin
            lsValid_i = (i < 6); lsAddr_i = 5'(20 + i); lsData_i = 16'hC000 + 16'(i);
            tick();
            if (i >= 1) begin
                checks++;
                if ({portBWriteEnable_o, portBWriteAddress_o, portBWriteData_o} !== {1'b1, 5'(19 + i), 16'hC000 + 16'(i - 1)}) begin
                    errors++;
                    $display("FAIL b2b%0d got we=%b %0d/%h exp 1 %0d/%h", i, portBWriteEnable_o,
                             portBWriteAddress_o, portBWriteData_o, 19 + i, 16'hC000 + 16'(i - 1));
                end
            end
        end
        lsValid_i = 1'b0;
        checks++; if (lsCount_o !== 3'd0) begin errors++; $display("FAIL b2b_count got %0d exp 0", lsCount_o); end
        tick();
        checks++; if (portBWriteEnable_o !== 1'b0) begin errors++; $display("FAIL b2b_end got %b exp 0", portBWriteEnable_o); end
    endtask

    task automatic test_reset_mid();
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            aluValid_i = 1'b1; aluAddr_i = 5'(4 + i); aluData_i = 16'h5500 + 16'(i);
            lsValid_i = (i == 0); lsAddr_i = 5'd30; lsData_i = 16'h7777;
            tick();
        end
        aluValid_i = 1'b0; lsValid_i = 1'b0;
        checks++; if ({aluCount_o, lsCount_o} !== {3'd3, 3'd1}) begin errors++; $display("FAIL mid_queued got %0d/%0d exp 3/1", aluCount_o, lsCount_o); end
        stall_i = 1'b0; reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        checks++; if ({aluCount_o, lsCount_o} !== 6'd0) begin errors++; $display("FAIL mid_counts got %0d/%0d exp 0/0", aluCount_o, lsCount_o); end
        checks++; if (idle_o !== 1'b1) begin errors++; $display("FAIL mid_idle got %b exp 1", idle_o); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if ({portAWriteEnable_o, portBWriteEnable_o} !== 2'b00) begin errors++; $display("FAIL mid_no_write%0d got %b exp 00", i, {portAWriteEnable_o, portBWriteEnable_o}); end
        end
    endtask

    // Scenario sequence and final report
    initial begin
        test_reset();
        test_single_alu();
        test_full_backpressure();
        test_collision();
        test_parallel();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
